// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX/MEM destination tracking, registered operand-forward selects, load-use stall and stall counter
module fwd_hazard_ctrl #(
  parameter int XLEN_REG = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [XLEN_REG-1:0] id_rs1,
  input  logic [XLEN_REG-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [XLEN_REG-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                stall,
  output logic [CNT_W-1:0]    stall_count
);
  logic                ex_valid, ex_reg_write, ex_mem_read;
  logic [XLEN_REG-1:0] ex_rd;
  logic                mem_valid, mem_reg_write, mem_mem_read;
  logic [XLEN_REG-1:0] mem_rd;
  logic                ex_prod, mem_prod, load_ex;
  logic                ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic [1:0]          sel_a, sel_b;
  always_comb begin
    ex_prod   = ex_valid && ex_reg_write && ex_rd != '0;
    mem_prod  = mem_valid && mem_reg_write && mem_rd != '0;
    ex_hit_a  = ex_prod && ex_rd == id_rs1;
    ex_hit_b  = ex_prod && ex_rd == id_rs2;
    mem_hit_a = mem_prod && mem_rd == id_rs1;
    mem_hit_b = mem_prod && mem_rd == id_rs2;
    stall     = id_valid && !flush && ex_mem_read &&
                ((id_use_rs1 && ex_hit_a) || (id_use_rs2 && ex_hit_b));
    load_ex   = id_valid && !flush && !stall;
    sel_a     = !(load_ex && id_use_rs1) ? 2'b00 : ex_hit_a ? 2'b10 : mem_hit_a ? 2'b01 : 2'b00;
    sel_b     = !(load_ex && id_use_rs2) ? 2'b00 : ex_hit_b ? 2'b10 : mem_hit_b ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_rd        <= '0;
      fwd_a_sel     <= 2'b00;
      fwd_b_sel     <= 2'b00;
      stall_count   <= '0;
    end else begin
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      mem_rd        <= ex_rd;
      ex_valid      <= load_ex;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_rd         <= id_rd;
      fwd_a_sel     <= sel_a;
      fwd_b_sel     <= sel_b;
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed vectors for forwarding selects, load-use stall and counter saturation
module tb_fwd_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fa_s, fb_s;
  logic        stall, stall_s;
  logic [15:0] stall_count;
  logic [3:0]  cnt_s;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  fwd_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
  );
  // narrow counter copy so saturation is reachable in a short run
  fwd_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fa_s), .fwd_b_sel(fb_s), .stall(stall_s), .stall_count(cnt_s)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
  endtask
  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    drive(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    nop();
    cyc();
    chk("rst_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("rst_b", {14'd0, fwd_b_sel}, 16'd0);
    chk("rst_cnt", stall_count, 16'd0);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    rst_n = 1'b1;
    alu(5'd1, 5'd2, 5'd5); cyc();
    alu(5'd5, 5'd6, 5'd8);
    chk("dist1_stall", {15'd0, stall}, 16'd0);
    cyc();
    chk("dist1_a", {14'd0, fwd_a_sel}, 16'd2);
    chk("dist1_b", {14'd0, fwd_b_sel}, 16'd0);
    alu(5'd1, 5'd2, 5'd7); cyc();
    nop(); cyc();
    alu(5'd1, 5'd7, 5'd9); cyc();
    chk("dist2_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("dist2_b", {14'd0, fwd_b_sel}, 16'd1);
    alu(5'd1, 5'd2, 5'd3); cyc();
    alu(5'd1, 5'd2, 5'd3); cyc();
    alu(5'd3, 5'd3, 5'd4); cyc();
    chk("young_a", {14'd0, fwd_a_sel}, 16'd2);
    chk("young_b", {14'd0, fwd_b_sel}, 16'd2);
    alu(5'd1, 5'd2, 5'd13); cyc();
    nop(); cyc();
    nop(); cyc();
    alu(5'd13, 5'd13, 5'd14); cyc();
    chk("dist3_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("dist3_b", {14'd0, fwd_b_sel}, 16'd0);
    alu(5'd1, 5'd2, 5'd0); cyc();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0); cyc();
    alu(5'd0, 5'd0, 5'd15);
    chk("x0_stall", {15'd0, stall}, 16'd0);
    cyc();
    chk("x0_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("x0_b", {14'd0, fwd_b_sel}, 16'd0);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0); cyc();
    alu(5'd1, 5'd6, 5'd10);
    chk("lu_stall", {15'd0, stall}, 16'd1);
    cyc();
    chk("lu_cnt", stall_count, 16'd1);
    chk("lu_bubble_b", {14'd0, fwd_b_sel}, 16'd0);
    chk("lu_stall_once", {15'd0, stall}, 16'd0);
    cyc();
    chk("lu_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("lu_b", {14'd0, fwd_b_sel}, 16'd1);
    chk("lu_cnt_hold", stall_count, 16'd1);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0); cyc();
    alu(5'd1, 5'd2, 5'd16);
    chk("indep_stall", {15'd0, stall}, 16'd0);
    cyc();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0); cyc();
    drive(1'b1, 5'd11, 5'd11, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b1);
    chk("flush_stall", {15'd0, stall}, 16'd0);
    cyc();
    chk("flush_cnt", stall_count, 16'd1);
    chk("flush_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("flush_b", {14'd0, fwd_b_sel}, 16'd0);
    alu(5'd1, 5'd2, 5'd12); cyc();
    rst_n = 1'b0;
    nop(); cyc();
    chk("mid_rst_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("mid_rst_cnt", stall_count, 16'd0);
    rst_n = 1'b1;
    alu(5'd12, 5'd12, 5'd18); cyc();
    chk("post_rst_a", {14'd0, fwd_a_sel}, 16'd0);
    chk("post_rst_b", {14'd0, fwd_b_sel}, 16'd0);
    rst_n = 1'b0;
    nop(); cyc();
    rst_n = 1'b1;
    drive(1'b1, 5'd6, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cyc();
    chk("sat_cnt_wide", stall_count, 16'd20);
    chk("sat_cnt_narrow", {12'd0, cnt_s}, 16'h000f);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
